// File: rtl/out_channel_pkg.sv
// Shared types and helpers for the output-channel checker slice.
package out_channel_pkg;

  // Checker phases: accept words, finish comparing buffered words, report.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Word width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 12;

  // Pointer width for a circular buffer of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Circular word buffer: DEPTH entries, one push and one pop per cycle,
// registered occupancy count (0..DEPTH) and full/empty flags.
module out_fifo
  import out_channel_pkg::*;
#(
  parameter  int W     = DEFAULT_WIDTH,
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Requests are ignored when they would overflow or underflow the buffer.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; count moves only when exactly one side acts.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_channel_checker.sv
// Buffers words emitted by the executor's out instruction and compares them,
// in order, with a loaded expected table; reports pass/fail once the program
// has ended and every buffered word has been compared.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// out_valid may be raised at any time; out_ready depends only on registered
// state (COLLECT and FIFO not full), never on out_valid or a same-cycle pop.
module out_channel_checker
  import out_channel_pkg::*;
#(
  parameter  int MemoryElementWidth = DEFAULT_WIDTH,
  parameter  int NOut               = 4,
  parameter  int NExpected          = 4,
  localparam int EAW                = (NExpected > 1) ? $clog2(NExpected) : 1,
  localparam int CW                 = $clog2(NExpected + 1) + 1,
  localparam int PW                 = ptr_width(NOut)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          out_valid,
  output logic                          out_ready,
  input  logic [MemoryElementWidth-1:0] out_data,
  input  logic                          finish_req,
  input  logic                          exp_we,
  input  logic [EAW-1:0]                exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  output logic                          finished,
  output logic                          success,
  output logic [CW-1:0]                 checked,
  output logic [CW-1:0]                 first_bad,
  output logic [1:0]                    dbg_state
);

  localparam logic [CW-1:0]  NEXP_C = CW'(NExpected);
  localparam logic [CW-1:0]  CMAX   = '1;
  localparam logic [EAW:0]   NEXP_A = (EAW+1)'(NExpected);

  state_t                        state;
  state_t                        next_state;
  logic [MemoryElementWidth-1:0] exp_mem [NExpected];
  logic [MemoryElementWidth-1:0] head;
  logic                          full;
  logic                          empty;
  logic [PW:0]                   count;
  logic                          push;
  logic                          pop;
  logic                          fail;
  logic                          in_range;
  logic                          bad;
  logic                          enter_done;

  assign out_ready  = (state == COLLECT) && !full;
  assign push       = out_valid && out_ready;
  assign pop        = (state != DONE) && !empty;
  assign in_range   = (checked < NEXP_C);
  // Past the end of the table every word is an unexpected extra.
  assign bad        = !in_range || (head != exp_mem[checked[EAW-1:0]]);
  assign enter_done = (state == DRAIN) && (next_state == DONE);
  assign dbg_state  = state;

  out_fifo #(
    .W     (MemoryElementWidth),
    .DEPTH (NOut)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (out_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Expected table: written any time, deliberately untouched by reset.
  always_ff @(posedge clock) begin
    if (exp_we && ({1'b0, exp_addr} < NEXP_A)) exp_mem[exp_addr] <= exp_data;
  end

  // Phase register.
  always_ff @(posedge clock) begin
    if (reset) state <= COLLECT;
    else       state <= next_state;
  end

  // Phase transitions: end-of-program starts draining; report once empty.
  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (finish_req) next_state = DRAIN;
      DRAIN:   if (count == '0) next_state = DONE;
      default: next_state = state;
    endcase
  end

  // Compare bookkeeping and final verdict; DONE freezes everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      fail      <= 1'b0;
      checked   <= '0;
      first_bad <= '1;
      finished  <= 1'b0;
      success   <= 1'b0;
    end else begin
      if (pop) begin
        if (bad) begin
          fail <= 1'b1;
          if (!fail) first_bad <= checked;
        end
        if (checked != CMAX) checked <= checked + 1'b1;
      end
      if (enter_done) begin
        finished <= 1'b1;
        success  <= !fail && (checked == NEXP_C);
        // Short output with no earlier mismatch: the first missing word is bad.
        if (!fail && in_range) first_bad <= checked;
      end
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Self-checking bench for out_channel_checker.
module tb_out_channel_checker;
  import out_channel_pkg::*;

  localparam int W    = 12;
  localparam int NOUT = 4;
  localparam int NEXP = 4;
  localparam int EAW  = 2;
  localparam int CW   = 4;

  logic          clock;
  logic          reset;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          finish_req;
  logic          exp_we;
  logic [EAW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic          finished;
  logic          success;
  logic [CW-1:0] checked;
  logic [CW-1:0] first_bad;
  logic [1:0]    dbg_state;

  int vectors;
  int miscompares;
  int accepted_n;

  logic [W-1:0] tbl [NEXP];
  logic [W-1:0] stim_q[$];
  logic [W-1:0] exp_q[$];

  out_channel_checker #(
    .MemoryElementWidth (W),
    .NOut               (NOUT),
    .NExpected          (NEXP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .finish_req (finish_req),
    .exp_we     (exp_we),
    .exp_addr   (exp_addr),
    .exp_data   (exp_data),
    .finished   (finished),
    .success    (success),
    .checked    (checked),
    .first_bad  (first_bad),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Count of words actually handed over, used to derive occupancy.
  always @(posedge clock) begin
    if (reset) accepted_n <= 0;
    else if (out_valid && out_ready) accepted_n <= accepted_n + 1;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; out_valid = 1'b0; finish_req = 1'b0; exp_we = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_table(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
  endtask

  task automatic load_table();
    for (int i = 0; i < NEXP; i++) begin
      @(negedge clock);
      exp_we = 1'b1; exp_addr = EAW'(i); exp_data = tbl[i];
    end
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  // Push stim_q in order with random idle gaps; record accepted words.
  task automatic drive_words(input bit fin_last, input int max_gap, output bit timed_out);
    exp_q.delete();
    timed_out = 1'b0;
    for (int i = 0; i < stim_q.size(); i++) begin
      int wait_n;
      repeat ($urandom_range(max_gap, 0)) @(negedge clock);
      out_valid  = 1'b1;
      out_data   = stim_q[i];
      finish_req = fin_last && (i == stim_q.size() - 1);
      wait_n = 0;
      while (!out_ready && wait_n < 20) begin
        @(negedge clock);
        wait_n++;
      end
      if (!out_ready) begin
        timed_out = 1'b1; out_valid = 1'b0; finish_req = 1'b0;
        break;
      end
      @(posedge clock);
      exp_q.push_back(stim_q[i]);
      @(negedge clock);
      out_valid = 1'b0; finish_req = 1'b0;
    end
  endtask

  task automatic pulse_finish();
    finish_req = 1'b1;
    @(negedge clock);
    finish_req = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out, output bit saw_drain);
    int n;
    n = 0; saw_drain = 1'b0;
    while (finished !== 1'b1 && n < 40) begin
      if (dbg_state == 2'(DRAIN)) saw_drain = 1'b1;
      @(negedge clock);
      n++;
    end
    timed_out = (finished !== 1'b1);
  endtask

  // ---------------- reference model ----------------
  // Verdict from the rules: words are compared in arrival order; the first
  // word that differs or lies beyond the table is bad; if none is bad and too
  // few arrived, the first missing index is bad; success iff nothing is bad.
  function automatic void model(output bit m_succ, output logic [CW-1:0] m_chk,
                                output logic [CW-1:0] m_fb);
    int n, fb;
    n = exp_q.size(); fb = -1;
    for (int i = 0; i < n; i++) begin
      if (fb < 0) begin
        if (i >= NEXP) fb = i;
        else if (exp_q[i] !== tbl[i]) fb = i;
      end
    end
    if (fb < 0 && n < NEXP) fb = n;
    m_succ = (fb < 0);
    m_chk  = (n > 15) ? CW'(15) : CW'(n);
    m_fb   = (fb < 0) ? '1 : CW'(fb);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished got %b want 0", finished); end
    vectors++; if (success !== 1'b0) begin miscompares++; $display("FAIL reset_success got %b want 0", success); end
    vectors++; if (checked !== 4'd0) begin miscompares++; $display("FAIL reset_checked got %0d want 0", checked); end
    vectors++; if (first_bad !== 4'hf) begin miscompares++; $display("FAIL reset_first_bad got %0d want 15", first_bad); end
    vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL reset_out_ready got %b want 1", out_ready); end
    vectors++; if (dbg_state !== 2'(COLLECT)) begin miscompares++; $display("FAIL reset_state got %0d want %0d", dbg_state, 2'(COLLECT)); end
  endtask

  // Full run from reset using stim_q and the current table.
  task automatic test_sequence(input string name, input bit fin_last, input int max_gap);
    bit to_drive, to_done, saw_drain, m_succ, use_last;
    logic [CW-1:0] m_chk, m_fb;
    do_reset();
    use_last = fin_last && (stim_q.size() > 0);
    drive_words(use_last, max_gap, to_drive);
    if (!use_last) pulse_finish();
    wait_done(to_done, saw_drain);
    model(m_succ, m_chk, m_fb);
    vectors++; if (to_drive || to_done) begin miscompares++; $display("FAIL %s_timeout drive=%0b done=%0b want 0 0", name, to_drive, to_done); end
    vectors++; if (success !== m_succ) begin miscompares++; $display("FAIL %s_success got %b want %b", name, success, m_succ); end
    vectors++; if (checked !== m_chk) begin miscompares++; $display("FAIL %s_checked got %0d want %0d", name, checked, m_chk); end
    vectors++; if (first_bad !== m_fb) begin miscompares++; $display("FAIL %s_first_bad got %0d want %0d", name, first_bad, m_fb); end
    vectors++; if (saw_drain !== 1'b1) begin miscompares++; $display("FAIL %s_drain_seen got %b want 1", name, saw_drain); end
    repeat (2) @(negedge clock);
    vectors++; if (finished !== 1'b1 || out_ready !== 1'b0) begin miscompares++; $display("FAIL %s_done_hold finished=%b out_ready=%b want 1 0", name, finished, out_ready); end
  endtask

  task automatic test_all_match();
    set_table(12'd99, 12'd0, 12'd1, 12'd2); load_table();
    stim_q = {12'd99, 12'd0, 12'd1, 12'd2};
    test_sequence("all_match", 1'b0, 0);
  endtask

  task automatic test_mismatch();
    stim_q = {12'd99, 12'd0, 12'd7, 12'd2};
    test_sequence("mismatch", 1'b0, 0);
  endtask

  task automatic test_missing_extra();
    stim_q = {12'd99, 12'd0, 12'd1};
    test_sequence("missing", 1'b0, 1);
    stim_q = {12'd99, 12'd0, 12'd1, 12'd2, 12'd5};
    test_sequence("extra", 1'b0, 0);
  endtask

  task automatic test_finish_with_last();
    stim_q = {12'd99, 12'd0, 12'd1, 12'd2};
    test_sequence("finish_with_last", 1'b1, 0);
  endtask

  // Hold out_valid across six words; ready must track occupancy < NOut.
  task automatic test_back_to_back();
    int idx, guard, occ;
    bit rdy, to_done, saw_drain, m_succ;
    logic [CW-1:0] m_chk, m_fb;
    do_reset();
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(W'($urandom_range(4095, 0)));
    stim_q[0] = tbl[0]; stim_q[1] = tbl[1];
    exp_q.delete();
    idx = 0; guard = 0;
    out_valid = 1'b1; out_data = stim_q[0];
    while (idx < 6 && guard < 40) begin
      rdy = out_ready;
      occ = accepted_n - int'(checked);
      vectors++; if (rdy !== (occ < NOUT)) begin miscompares++; $display("FAIL b2b_ready got %b want %b (occupancy %0d)", rdy, (occ < NOUT), occ); end
      @(posedge clock);
      if (rdy) begin exp_q.push_back(stim_q[idx]); idx++; end
      @(negedge clock);
      if (idx < 6) out_data = stim_q[idx];
      guard++;
    end
    out_valid = 1'b0;
    pulse_finish();
    wait_done(to_done, saw_drain);
    model(m_succ, m_chk, m_fb);
    vectors++; if (idx != 6 || to_done) begin miscompares++; $display("FAIL b2b_timeout pushed=%0d done_to=%0b want 6 0", idx, to_done); end
    vectors++; if (checked !== m_chk) begin miscompares++; $display("FAIL b2b_checked got %0d want %0d", checked, m_chk); end
    vectors++; if (first_bad !== m_fb) begin miscompares++; $display("FAIL b2b_first_bad got %0d want %0d", first_bad, m_fb); end
    vectors++; if (success !== m_succ) begin miscompares++; $display("FAIL b2b_success got %b want %b", success, m_succ); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int len;
      for (int i = 0; i < NEXP; i++) tbl[i] = W'($urandom_range(4095, 0));
      load_table();
      len = $urandom_range(6, 0);
      stim_q.delete();
      for (int i = 0; i < len; i++) begin
        if (i < NEXP && $urandom_range(3, 0) != 0) stim_q.push_back(tbl[i]);
        else stim_q.push_back(W'($urandom_range(4095, 0)));
      end
      test_sequence("random", 1'($urandom_range(1, 0)), 2);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit to_drive;
    set_table(12'd99, 12'd0, 12'd1, 12'd2); load_table();
    do_reset();
    stim_q = {12'd99, 12'd0};
    drive_words(1'b0, 0, to_drive);
    pulse_finish();
    vectors++; if (to_drive || dbg_state !== 2'(DRAIN)) begin miscompares++; $display("FAIL mid_drain_state got %0d want %0d", dbg_state, 2'(DRAIN)); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL mid_reset_finished got %b want 0", finished); end
    vectors++; if (checked !== 4'd0) begin miscompares++; $display("FAIL mid_reset_checked got %0d want 0", checked); end
    vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_out_ready got %b want 1", out_ready); end
    vectors++; if (first_bad !== 4'hf) begin miscompares++; $display("FAIL mid_reset_first_bad got %0d want 15", first_bad); end
    stim_q = {12'd99, 12'd0, 12'd1, 12'd2};
    test_sequence("rerun_after_reset", 1'b0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; out_valid = 1'b0; out_data = '0; finish_req = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    test_reset();
    test_all_match();
    test_mismatch();
    test_missing_extra();
    test_finish_with_last();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
